// File: rtl/fpga_fabric_pkg.sv
// Shared fabric definitions: carry-cell configuration layout and carry-in source encodings.
package fpga_fabric_pkg;

  localparam int CARRY_CFG_W = 4;

  localparam logic [1:0] CIN_CHAIN = 2'b00;
  localparam logic [1:0] CIN_ZERO  = 2'b01;
  localparam logic [1:0] CIN_ONE   = 2'b10;

  // Bit order matches the serial scan order: cin_sel sits in the low bits, shifted in first.
  typedef struct packed {
    logic       co_reg;
    logic       inv_i1;
    logic [1:0] cin_sel;
  } carry_cfg_t;

endpackage

// File: rtl/fpga_carry_logic_if.sv
// Operand, carry-chain and configuration-scan signals of one carry cell.
interface fpga_carry_logic_if;

  logic cfg_en_i;
  logic cfg_d_i;
  logic cfg_q_o;
  logic carry_in_i;
  logic i0_i;
  logic i1_i;
  logic carry_out_o;
  logic sum_o;
  logic p_o;
  logic g_o;

  modport master (
    output cfg_en_i, cfg_d_i, carry_in_i, i0_i, i1_i,
    input  cfg_q_o, carry_out_o, sum_o, p_o, g_o
  );

  modport slave (
    input  cfg_en_i, cfg_d_i, carry_in_i, i0_i, i1_i,
    output cfg_q_o, carry_out_o, sum_o, p_o, g_o
  );

endinterface

// File: rtl/fpga_cfg_shreg.sv
// Generic N-bit configuration scan register: shifts toward bit 0 while en is high, sync reset.
// Powers up at zero so an unclocked cell starts in its default configuration.
module fpga_cfg_shreg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (en) begin
      sr <= {d, sr[W-1:1]};
    end
  end

  assign q = sr;

endmodule

// File: rtl/fpga_carry_logic.sv
// Per-bit carry cell: full-adder carry/sum with selectable carry-in, optional i1 inversion
// and optional registered carry-out. Combinational path has zero latency; registered carry lags by one clock.
module fpga_carry_logic
  import fpga_fabric_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  fpga_carry_logic_if.slave   cl
);

  logic [CARRY_CFG_W-1:0] cfg_vec;
  carry_cfg_t             cfg;
  logic                   a;
  logic                   b;
  logic                   c;
  logic                   co;
  logic                   carry_q = 1'b0;

  fpga_cfg_shreg #(
    .W (CARRY_CFG_W)
  ) u_cfg (
    .clk (clk_i),
    .rst (rst_i),
    .en  (cl.cfg_en_i),
    .d   (cl.cfg_d_i),
    .q   (cfg_vec)
  );

  // Datapath follows the live scan contents; there is no shadow copy.
  assign cfg = carry_cfg_t'(cfg_vec);

  assign a = cl.i0_i;
  assign b = cl.i1_i ^ cfg.inv_i1;

  always_comb begin
    c = cl.carry_in_i;
    case (cfg.cin_sel)
      CIN_ZERO: c = 1'b0;
      CIN_ONE:  c = 1'b1;
      default:  c = cl.carry_in_i;
    endcase
  end

  assign co = (a & b) | (c & (a ^ b));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= co;
    end
  end

  assign cl.carry_out_o = cfg.co_reg ? carry_q : co;
  assign cl.sum_o       = a ^ b ^ c;
  assign cl.p_o         = a ^ b;
  assign cl.g_o         = a & b;
  assign cl.cfg_q_o     = cfg_vec[0];

endmodule

// File: tb/tb_fpga_carry_logic.sv
// Scoreboarded bench for the carry cell: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against {carry_out, sum, p, g, cfg_q}.
module tb_fpga_carry_logic;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fpga_carry_logic_if cif ();

  fpga_carry_logic dut (
    .clk_i (clk),
    .rst_i (rst),
    .cl    (cif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] exp;
    bit         q_only;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push_all(input string nm, input logic co, input logic sum,
                          input logic p, input logic g, input logic q);
    exp_t e;
    e.name   = nm;
    e.exp    = {co, sum, p, g, q};
    e.q_only = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_q(input string nm, input logic q);
    exp_t e;
    e.name   = nm;
    e.exp    = {4'b0000, q};
    e.q_only = 1'b1;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic i0, input logic i1, input logic ci);
    cif.i0_i       = i0;
    cif.i1_i       = i1;
    cif.carry_in_i = ci;
  endtask

  // Bits go in LSB first; cfg holds the full word on return, with en already dropped.
  task automatic shift_cfg(input logic [3:0] bits);
    for (int k = 0; k < 4; k++) begin
      step();
      cif.cfg_en_i = 1'b1;
      cif.cfg_d_i  = bits[k];
    end
    step();
    cif.cfg_en_i = 1'b0;
    cif.cfg_d_i  = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [4:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {cif.carry_out_o, cif.sum_o, cif.p_o, cif.g_o, cif.cfg_q_o};
      tests++;
      if (e.q_only ? (act[0] !== e.exp[0]) : (act !== e.exp)) begin
        fails++;
        $display("FAIL %s: co/sum/p/g/q got %b required %b%s", e.name, act, e.exp,
                 e.q_only ? " (cfg_q only)" : "");
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [7:0] co_tbl;
    logic [7:0] sum_tbl;
    logic [2:0] v;

    co_tbl  = 8'b1110_1000;
    sum_tbl = 8'b1001_0110;
    cif.cfg_en_i = 1'b0;
    cif.cfg_d_i  = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);

    // Power-up default: plain full adder, never reset.
    for (int n = 0; n < 8; n++) begin
      step();
      v = n[2:0];
      set_in(v[2], v[1], v[0]);
      push_all($sformatf("default_%0d%0d%0d", v[2], v[1], v[0]),
               co_tbl[n], sum_tbl[n], v[2] ^ v[1], v[2] & v[1], 1'b0);
    end

    // Carry-in forced to 1.
    shift_cfg(4'b0010);
    set_in(1'b1, 1'b0, 1'b0);
    push_all("cin_one_ci0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b1, 1'b0, 1'b1);
    push_all("cin_one_ci1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // i1 inverted, carry-in forced to 0 (chain input held high to prove it is ignored).
    shift_cfg(4'b0101);
    set_in(1'b1, 1'b1, 1'b1);
    push_all("inv_zero_11", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_in(1'b1, 1'b0, 1'b1);
    push_all("inv_zero_10", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Registered carry-out.
    step();
    set_in(1'b0, 1'b0, 1'b0);
    shift_cfg(4'b1000);
    set_in(1'b1, 1'b1, 1'b0);
    push_all("reg_rise_pending", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    push_all("reg_rise", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    set_in(1'b0, 1'b1, 1'b0);
    push_all("reg_fall_pending", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    push_all("reg_fall", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b1, 1'b1, 1'b0);
    push_all("reg_rise2_pending", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    push_all("reg_rise2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset while carry_q = 1 in registered mode.
    step();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    push_all("rst_pending", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    push_all("rst_clears", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 1'b1, 1'b1);
    push_all("rst_comb_011", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Scan pattern through to cfg_q.
    shift_cfg(4'b1101);
    push_q("scan_out0", 1'b1);
    cif.cfg_en_i = 1'b1;
    cif.cfg_d_i  = 1'b0;
    step();
    push_q("scan_out1", 1'b0);
    step();
    push_q("scan_out2", 1'b1);
    step();
    push_q("scan_out3", 1'b1);
    step();
    cif.cfg_en_i = 1'b0;

    // Reset wins over a simultaneous shift.
    shift_cfg(4'b1111);
    push_q("ovr_loaded", 1'b1);
    step();
    rst = 1'b1;
    cif.cfg_en_i = 1'b1;
    cif.cfg_d_i  = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    cif.cfg_en_i = 1'b0;
    cif.cfg_d_i  = 1'b0;
    push_all("ovr_cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 1'b1, 1'b1);
    push_all("ovr_comb_011", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    step();
    step();
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
